ula_b_operand_stage: RTL and testbench

- Next-generation ALU operand-B path for the multicycle datapath.
- Selects one of NUM_SRC WIDTH-bit sources, or a built-in constant channel (the PC increment of 4 by default), and registers the result.
- Optionally left-shifts the selected value by a run-time amount.
- Hands the value to the ALU through a valid/ready handshake, so the control unit can stall the operand while the ALU is busy.

---
 rtl/ula_b_operand_stage_if.sv | 42 ++++
 rtl/ula_b_operand_stage.sv | 127 ++++++++++++
 tb/tb_ula_b_operand_stage.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ula_b_operand_stage_if.sv
// Operand-B stage bus: capture request, packed sources and the valid/ready result handshake.
// Handshake: data_out is transferred on a rising edge where valid=1 and ready=1;
// valid stays high with data_out stable until then, and ready while valid=0 is ignored.
interface ula_b_operand_stage_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_SRC = 5,
    parameter int SEL_W   = 3,
    parameter int SHAMT_W = 5
);
    logic                     start;
    logic [SEL_W-1:0]         sel;
    logic [NUM_SRC*WIDTH-1:0] src_flat;
    logic [SHAMT_W-1:0]       shamt;
    logic                     ready;
    logic                     busy;
    logic                     valid;
    logic [WIDTH-1:0]         data_out;

    // Control unit / ALU side.
    modport master (
        output start,
        output sel,
        output src_flat,
        output shamt,
        output ready,
        input  busy,
        input  valid,
        input  data_out
    );

    // Operand stage side.
    modport slave (
        input  start,
        input  sel,
        input  src_flat,
        input  shamt,
        input  ready,
        output busy,
        output valid,
        output data_out
    );
endinterface

// File: rtl/ula_b_operand_stage.sv
// ALU operand-B stage: channel select (with a constant channel), optional left shift, registered
// valid/ready output. Define ULAB_BARREL_SHIFT_EN for a single-cycle barrel shift instead of the serial one.
module ula_b_operand_stage #(
    parameter int              WIDTH     = 32,
    parameter int              NUM_SRC   = 5,
    parameter int              SEL_W     = 3,
    parameter int              CONST_IDX = 1,
    parameter logic [WIDTH-1:0] CONST_VAL = 4,
    parameter int              SHAMT_W   = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ula_b_operand_stage_if.slave bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] chan_val;

    // Unmatched selects (sel >= NUM_SRC) fall through to zero.
    always_comb begin
        chan_val = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (bus.sel == SEL_W'(k)) begin
                chan_val = (k == CONST_IDX) ? CONST_VAL : bus.src_flat[k*WIDTH +: WIDTH];
            end
        end
    end

`ifdef ULAB_BARREL_SHIFT_EN

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = chan_val << bus.shamt;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
        end
    end

`else

    logic [SHAMT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = chan_val;
                    cnt_d   = bus.shamt;
                    state_d = (bus.shamt == '0) ? HOLD : SHIFT;
                end
            end
            SHIFT: begin
                // One bit per cycle; the MSB falls off the top.
                data_d = {data_q[WIDTH-2:0], 1'b0};
                cnt_d  = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

`endif

    assign bus.busy     = busy_q;
    assign bus.valid    = (state_q == HOLD);
    assign bus.data_out = data_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_ula_b_operand_stage.sv
// Directed bench for ula_b_operand_stage: constant channel, serial/barrel shift, boundaries,
// illegal select, backpressure and asynchronous reset mid-operation.
module tb_ula_b_operand_stage;

    localparam int WIDTH   = 32;
    localparam int NUM_SRC = 5;
    localparam int SEL_W   = 3;
    localparam int SHAMT_W = 5;

    logic       clk;
    logic       reset_n;
    logic [1:0] dbg_state;

    int checks;
    int passes;

    ula_b_operand_stage_if #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .SHAMT_W(SHAMT_W)
    ) bus ();

    ula_b_operand_stage #(
        .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
        .CONST_IDX(1), .CONST_VAL(32'd4), .SHAMT_W(SHAMT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int latency(input logic [4:0] sh);
`ifdef ULAB_BARREL_SHIFT_EN
        return 1;
`else
        return int'(sh) + 1;
`endif
    endfunction

    task automatic set_src(input int k, input logic [31:0] val);
        bus.src_flat[k*WIDTH +: WIDTH] = val;
    endtask

    // Pulse start for one cycle, scramble the don't-care inputs, then follow the op until valid.
    task automatic run_op(input string tag, input logic [2:0] s, input logic [4:0] sh,
                          input logic [31:0] exp_d);
        int lat;
        lat = latency(sh);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sel   = s;
        bus.shamt = sh;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.sel      = 3'($urandom_range(0, 7));
        bus.shamt    = 5'($urandom_range(0, 31));
        bus.src_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
        for (int i = 1; i < lat; i++) begin
            check({tag, "_busy_wait"}, 32'(bus.busy), 32'd1);
            check({tag, "_valid_wait"}, 32'(bus.valid), 32'd0);
            @(negedge clk);
        end
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        check({tag, "_data"}, bus.data_out, exp_d);
    endtask

    task automatic accept(input string tag, input logic [31:0] exp_d);
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check({tag, "_acc_valid"}, 32'(bus.valid), 32'd0);
        check({tag, "_acc_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_acc_data"}, bus.data_out, exp_d);
        check({tag, "_acc_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        checks       = 0;
        passes       = 0;
        reset_n      = 1'b0;
        bus.start    = 1'b0;
        bus.sel      = '0;
        bus.shamt    = '0;
        bus.ready    = 1'b0;
        bus.src_flat = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_data", bus.data_out, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // ready while idle must not do anything
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        check("idle_ready_valid", 32'(bus.valid), 32'd0);
        check("idle_ready_busy", 32'(bus.busy), 32'd0);

        // Constant channel overrides its src_flat slice
        set_src(1, 32'hDEAD_BEEF);
        run_op("const", 3'd1, 5'd0, 32'h0000_0004);
        accept("const", 32'h0000_0004);

        set_src(2, 32'h0000_0003);
        run_op("shift2", 3'd2, 5'd2, 32'h0000_000C);
        accept("shift2", 32'h0000_000C);

        set_src(0, 32'h0000_0001);
        run_op("shift31", 3'd0, 5'd31, 32'h8000_0000);
        accept("shift31", 32'h8000_0000);

        set_src(0, 32'hFFFF_FFFF);
        run_op("ones4", 3'd0, 5'd4, 32'hFFFF_FFF0);
        accept("ones4", 32'hFFFF_FFF0);

        set_src(0, 32'hFFFF_FFFF);
        set_src(4, 32'hFFFF_FFFF);
        run_op("illegal6", 3'd6, 5'd3, 32'h0000_0000);
        accept("illegal6", 32'h0000_0000);

        // Backpressure: HOLD is sticky while ready=0, whatever the inputs do
        set_src(3, 32'hA5A5_0001);
        run_op("bp", 3'd3, 5'd1, 32'h4B4A_0002);
        for (int i = 0; i < 5; i++) begin
            bus.start    = ~bus.start;
            bus.sel      = 3'($urandom_range(0, 4));
            bus.shamt    = 5'($urandom_range(0, 31));
            bus.src_flat = {$urandom, $urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check("bp_hold_valid", 32'(bus.valid), 32'd1);
            check("bp_hold_data", bus.data_out, 32'h4B4A_0002);
            check("bp_hold_state", 32'(dbg_state), 32'd2);
        end
        // start together with the accepting ready is dropped
        bus.start = 1'b1;
        bus.sel   = 3'd3;
        bus.shamt = 5'd0;
        bus.ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.ready = 1'b0;
        check("bp_acc_valid", 32'(bus.valid), 32'd0);
        check("bp_acc_busy", 32'(bus.busy), 32'd0);
        check("bp_acc_data", bus.data_out, 32'h4B4A_0002);
        @(negedge clk);
        check("bp_no_capture_state", 32'(dbg_state), 32'd0);
        check("bp_no_capture_valid", 32'(bus.valid), 32'd0);

        // Asynchronous reset in the middle of an operation
        set_src(0, 32'h0000_0055);
        @(negedge clk);
        bus.start = 1'b1;
        bus.sel   = 3'd0;
        bus.shamt = 5'd10;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
`ifndef ULAB_BARREL_SHIFT_EN
        check("midop_in_shift", 32'(dbg_state), 32'd1);
`endif
        check("midop_busy", 32'(bus.busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_data", bus.data_out, 32'd0);
        check("arst_valid", 32'(bus.valid), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        set_src(4, 32'h1234_5678);
        run_op("post_rst", 3'd4, 5'd0, 32'h1234_5678);
        accept("post_rst", 32'h1234_5678);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Safety net against a stuck run
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
